// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
// Shared definitions for the pipeline stall/flush controller:
//   XZR            - architectural zero register index; never part of a hazard
//   shadow_entry_t - hazard-relevant fields tracked for one in-flight instruction
//   ENTRY_W        - flattened width of shadow_entry_t, used on module ports
//   CNT_W_DEFAULT  - default width of the stall/flush event counters
//   src_match()    - true when a used source register names a real destination
package pipe_ctrl_pkg;

  localparam logic [4:0] XZR = 5'd31;

  localparam int CNT_W_DEFAULT = 16;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
    logic       flag_write;
  } shadow_entry_t;

  localparam int ENTRY_W = $bits(shadow_entry_t);

  // A source that is not read, or a destination of XZR, can never create a
  // dependency, so both are filtered here rather than at every call site.
  function automatic logic src_match(input logic       used,
                                     input logic [4:0] src,
                                     input logic [4:0] rd);
    return used && (src == rd) && (rd != XZR);
  endfunction

endpackage

// File: rtl/hazard_shadow_stage.sv
// hazard_shadow_stage
// One shadow pipeline entry (flattened shadow_entry_t).
// Ports:
//   clk   in  pipeline clock
//   reset in  asynchronous, active-high reset; entry becomes invalid
//   load  in  capture d on the next clock edge
//   clear in  invalidate the entry on the next clock edge; wins over load
//   d     in  next entry contents
//   q     out current entry contents
module hazard_shadow_stage
  import pipe_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               clear,
  input  logic [ENTRY_W-1:0] d,
  output logic [ENTRY_W-1:0] q
);

  // All-zero is an invalid entry, so clear and reset share the same value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Central stall/flush controller for the 5-stage pipeline. Shadows the
// hazard-relevant fields of the EX and MEM instructions, detects load-use and
// flag-use hazards against the ID instruction, squashes younger instructions
// on a taken branch in MEM, and keeps saturating stall/flush event counters.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   id_*                       fields of the instruction currently in ID
//   mem_take_branch            branch resolved taken in MEM this cycle
//   pc_enable, if_id_enable    low during a stall cycle
//   id_ex_enable               always 1; ID/EX is steered by id_ex_bubble
//   id_ex_bubble               zero the ID/EX control inputs (stall or flush)
//   if_id_flush, ex_mem_flush  squash IF/ID and EX/MEM on a taken branch
//   stall_count, flush_count   saturating debug event counters
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_flag_write,
  input  logic             id_reads_flags,
  input  logic             mem_take_branch,
  output logic             pc_enable,
  output logic             if_id_enable,
  output logic             id_ex_enable,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic             ex_mem_flush,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  shadow_entry_t      id_entry;
  shadow_entry_t      ex_entry;
  logic [ENTRY_W-1:0] ex_q;
  logic [ENTRY_W-1:0] mem_q;

  logic load_use;
  logic flag_hazard;
  logic stall;
  logic flush;

  assign id_entry = '{valid:      id_valid,
                      rd:         id_rd,
                      reg_write:  id_reg_write,
                      mem_read:   id_mem_read,
                      flag_write: id_flag_write};

  assign ex_entry = shadow_entry_t'(ex_q);

  // On a stall the EX shadow takes the bubble, which is what releases the
  // stall on the following cycle.
  hazard_shadow_stage u_ex_shadow (
    .clk   (clk),
    .reset (reset),
    .load  (1'b1),
    .clear (flush | stall),
    .d     (id_entry),
    .q     (ex_q)
  );

  // MEM keeps the full entry layout so the two shadows stay interchangeable.
  hazard_shadow_stage u_mem_shadow (
    .clk   (clk),
    .reset (reset),
    .load  (1'b1),
    .clear (flush),
    .d     (ex_q),
    .q     (mem_q)
  );

  assign load_use = ex_entry.valid & ex_entry.mem_read & ex_entry.reg_write &
                    (src_match(id_uses_rs1, id_rs1, ex_entry.rd) |
                     src_match(id_uses_rs2, id_rs2, ex_entry.rd));

  assign flag_hazard = ex_entry.valid & ex_entry.flag_write & id_reads_flags;

  // A taken branch squashes the ID instruction anyway, so it overrides any stall.
  assign flush = mem_take_branch;
  assign stall = id_valid & (load_use | flag_hazard) & ~flush;

  assign pc_enable    = ~stall;
  assign if_id_enable = ~stall;
  assign id_ex_enable = 1'b1;
  assign id_ex_bubble = stall | flush;
  assign if_id_flush  = flush;
  assign ex_mem_flush = flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
    end else if (stall && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flush_count <= '0;
    end else if (flush && (flush_count != {CNT_W{1'b1}})) begin
      flush_count <= flush_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
`timescale 1ns/1ps
module tb_pipeline_hazard_ctrl;

  // Narrow counters so both saturation points are reachable in a short run.
  localparam int W      = 8;
  localparam int CNT_MAX = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         id_valid;
  logic [4:0]   id_rs1, id_rs2, id_rd;
  logic         id_uses_rs1, id_uses_rs2;
  logic         id_reg_write, id_mem_read, id_flag_write, id_reads_flags;
  logic         mem_take_branch;
  logic         pc_enable, if_id_enable, id_ex_enable, id_ex_bubble;
  logic         if_id_flush, ex_mem_flush;
  logic [W-1:0] stall_count, flush_count;

  int checks = 0;
  int errors = 0;

  pipeline_hazard_ctrl #(.CNT_W(W)) dut (
    .clk            (clk),
    .reset          (reset),
    .id_valid       (id_valid),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_uses_rs1    (id_uses_rs1),
    .id_uses_rs2    (id_uses_rs2),
    .id_rd          (id_rd),
    .id_reg_write   (id_reg_write),
    .id_mem_read    (id_mem_read),
    .id_flag_write  (id_flag_write),
    .id_reads_flags (id_reads_flags),
    .mem_take_branch(mem_take_branch),
    .pc_enable      (pc_enable),
    .if_id_enable   (if_id_enable),
    .id_ex_enable   (id_ex_enable),
    .id_ex_bubble   (id_ex_bubble),
    .if_id_flush    (if_id_flush),
    .ex_mem_flush   (ex_mem_flush),
    .stall_count    (stall_count),
    .flush_count    (flush_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Instructions in flight past ID: slot 0 = EX, slot 1 = MEM.
  typedef struct {
    bit valid;
    int dest;
    bit writes_reg;
    bit is_load;
    bit sets_flags;
  } instr_t;

  instr_t inflight[2];
  int     m_stalls;
  int     m_flushes;

  function automatic bit reads_dest(input int d);
    if (d == 31) return 0;
    return (id_uses_rs1 && int'(id_rs1) == d) || (id_uses_rs2 && int'(id_rs2) == d);
  endfunction

  function automatic bit model_stall();
    bit lu, fl;
    lu = inflight[0].valid && inflight[0].is_load && inflight[0].writes_reg &&
         reads_dest(inflight[0].dest);
    fl = inflight[0].valid && inflight[0].sets_flags && id_reads_flags;
    return id_valid && (lu || fl) && !mem_take_branch;
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  always @(posedge clk or posedge reset) begin
    instr_t incoming;
    bit st;
    if (reset) begin
      inflight[0].valid = 0;
      inflight[1].valid = 0;
      m_stalls  = 0;
      m_flushes = 0;
    end else begin
      st = model_stall();
      incoming.valid      = id_valid;
      incoming.dest       = int'(id_rd);
      incoming.writes_reg = id_reg_write;
      incoming.is_load    = id_mem_read;
      incoming.sets_flags = id_flag_write;
      if (mem_take_branch) begin
        inflight[0].valid = 0;
        inflight[1].valid = 0;
        m_flushes = sat_inc(m_flushes);
      end else if (st) begin
        inflight[1] = inflight[0];
        inflight[0].valid = 0;
        m_stalls = sat_inc(m_stalls);
      end else begin
        inflight[1] = inflight[0];
        inflight[0] = incoming;
      end
    end
  end

  always @(negedge clk) begin
    bit es, ef;
    es = model_stall();
    ef = mem_take_branch;
    chk("cyc_pc_enable",    pc_enable,    !es);
    chk("cyc_if_id_enable", if_id_enable, !es);
    chk("cyc_id_ex_enable", id_ex_enable, 1);
    chk("cyc_id_ex_bubble", id_ex_bubble, es || ef);
    chk("cyc_if_id_flush",  if_id_flush,  ef);
    chk("cyc_ex_mem_flush", ex_mem_flush, ef);
    chk("cyc_stall_count",  stall_count,  m_stalls);
    chk("cyc_flush_count",  flush_count,  m_flushes);
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic id_set(input bit v, input int rs1, input int rs2, input bit u1,
                        input bit u2, input int rd, input bit rw, input bit mr,
                        input bit fw, input bit rf);
    id_valid       = v;
    id_rs1         = rs1[4:0];
    id_rs2         = rs2[4:0];
    id_uses_rs1    = u1;
    id_uses_rs2    = u2;
    id_rd          = rd[4:0];
    id_reg_write   = rw;
    id_mem_read    = mr;
    id_flag_write  = fw;
    id_reads_flags = rf;
  endtask

  task automatic id_idle();                       id_set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic id_load(input int rd, input int base); id_set(1, base, 0, 1, 0, rd, 1, 1, 0, 0); endtask
  task automatic id_alu(input int rd, input int a, input int b, input bit f);
    id_set(1, a, b, 1, 1, rd, 1, 0, f, 0);
  endtask
  task automatic id_blt();                        id_set(1, 0, 0, 0, 0, 0, 0, 0, 0, 1); endtask

  initial begin
    reset = 1'b1;
    mem_take_branch = 1'b0;
    id_idle();
    #3;
    chk("rst_pc_enable",    pc_enable, 1);
    chk("rst_if_id_enable", if_id_enable, 1);
    chk("rst_id_ex_enable", id_ex_enable, 1);
    chk("rst_bubble",       id_ex_bubble, 0);
    chk("rst_if_id_flush",  if_id_flush, 0);
    chk("rst_ex_mem_flush", ex_mem_flush, 0);
    chk("rst_stall_count",  stall_count, 0);
    chk("rst_flush_count",  flush_count, 0);
    step();
    reset = 1'b0;

    // LDUR X3 then ADD reading X3 as rs2: one stall cycle.
    step(); id_load(3, 1);   #1 chk("ldur_no_stall", pc_enable, 1);
    step(); id_alu(5, 4, 3, 0); #1;
    chk("lu_pc_enable", pc_enable, 0);
    chk("lu_if_id_enable", if_id_enable, 0);
    chk("lu_bubble", id_ex_bubble, 1);
    step(); #1;
    chk("lu_release", pc_enable, 1);
    chk("lu_stall_count", stall_count, 1);

    // Load into XZR never stalls.
    step(); id_load(31, 1);
    step(); id_alu(6, 31, 31, 0); #1 chk("xzr_no_stall", pc_enable, 1);

    // SUBS then BLT: flag stall; ADDS already in MEM: none.
    step(); id_alu(2, 1, 1, 1);
    step(); id_blt(); #1 chk("flag_stall", pc_enable, 0);
    step(); #1;
    chk("flag_release", pc_enable, 1);
    chk("flag_stall_count", stall_count, 2);
    step(); id_alu(8, 1, 1, 1);
    step(); id_idle();
    step(); id_blt(); #1 chk("flag_in_mem_no_stall", pc_enable, 1);

    // Matching register on an unused source, and an invalid ID slot.
    step(); id_load(4, 1);
    step(); id_alu(5, 1, 4, 0); id_uses_rs2 = 0; #1 chk("unused_rs2_no_stall", pc_enable, 1);
    step(); id_load(4, 1);
    step(); id_alu(5, 4, 0, 0); id_valid = 0; #1 chk("id_invalid_no_stall", pc_enable, 1);

    // Load-use hazard coinciding with a taken branch: flush only.
    step(); id_load(7, 1);
    step(); id_alu(9, 7, 7, 0); mem_take_branch = 1; #1;
    chk("br_if_id_flush", if_id_flush, 1);
    chk("br_ex_mem_flush", ex_mem_flush, 1);
    chk("br_bubble", id_ex_bubble, 1);
    chk("br_pc_enable", pc_enable, 1);
    step(); mem_take_branch = 0; #1;
    chk("br_shadow_cleared", pc_enable, 1);
    chk("br_flush_count", flush_count, 1);
    chk("br_stall_count", stall_count, 2);

    // Drive both counters well past saturation.
    for (int i = 0; i < 300; i++) begin
      step(); id_load(9, 1);
      step(); id_alu(10, 9, 9, 0);
    end
    step(); id_idle(); #1 chk("stall_saturated", stall_count, CNT_MAX);
    for (int i = 0; i < 300; i++) begin
      step(); mem_take_branch = 1;
    end
    step(); mem_take_branch = 0; #1 chk("flush_saturated", flush_count, CNT_MAX);

    // Reset during a stall cycle releases it without a clock edge.
    step(); id_load(3, 1);
    step(); id_alu(5, 4, 3, 0); #1 chk("pre_rst_stall", pc_enable, 0);
    reset = 1'b1; #1;
    chk("rst_mid_pc_enable", pc_enable, 1);
    chk("rst_mid_bubble", id_ex_bubble, 0);
    chk("rst_mid_stall_count", stall_count, 0);
    chk("rst_mid_flush_count", flush_count, 0);
    step(); reset = 1'b0;
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
